// File: rtl/addr_gen_seq.sv
// addr_gen_seq: base/stride/length address walker with dwell, pause, wrap.
// Define ADDR_GEN_SEQ_REPEAT_EN to add i_repeat (multi-pass one-shot runs).
module addr_gen_seq #(
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [ADDR_WIDTH-1:0] i_len,
  input  logic [ADDR_WIDTH-1:0] i_stride,
  input  logic [CNT_WIDTH-1:0]  i_dwell,
  input  logic [CNT_WIDTH-1:0]  i_pause,
  input  logic                  i_wrap,
`ifdef ADDR_GEN_SEQ_REPEAT_EN
  input  logic [7:0]            i_repeat,
`endif
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_valid,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  C_ONE = CNT_WIDTH'(1);

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [CNT_WIDTH-1:0]  dwell_q, dwell_d;
  logic [CNT_WIDTH-1:0]  pause_q, pause_d;
  logic                  wrap_q, wrap_d;

`ifdef ADDR_GEN_SEQ_REPEAT_EN
  logic [7:0]            rep_q, rep_d;
`endif

  logic [ADDR_WIDTH-1:0] len_m1;
  logic [ADDR_WIDTH-1:0] idx_inc;
  logic                  step;
  logic                  halt;

  // dwell of zero is treated as one cycle
  function automatic logic [CNT_WIDTH-1:0] dwell_m1(
    input logic [CNT_WIDTH-1:0] d
  );
    return (d == '0) ? '0 : d - C_ONE;
  endfunction

  assign len_m1  = len_q - A_ONE;
  assign idx_inc = idx_q + A_ONE;

  // state, counters, latched config and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      base_q   <= '0;
      len_q    <= '0;
      stride_q <= '0;
      dwell_q  <= '0;
      pause_q  <= '0;
      wrap_q   <= 1'b0;
`ifdef ADDR_GEN_SEQ_REPEAT_EN
      rep_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      len_q    <= len_d;
      stride_q <= stride_d;
      dwell_q  <= dwell_d;
      pause_q  <= pause_d;
      wrap_q   <= wrap_d;
`ifdef ADDR_GEN_SEQ_REPEAT_EN
      rep_q    <= rep_d;
`endif
    end
  end

  // next-state and next-output logic; en=0 holds everything
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = done_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    len_d    = len_q;
    stride_d = stride_q;
    dwell_d  = dwell_q;
    pause_d  = pause_q;
    wrap_d   = wrap_q;
`ifdef ADDR_GEN_SEQ_REPEAT_EN
    rep_d    = rep_q;
`endif
    step     = 1'b0;
    halt     = 1'b0;

    if (en) begin
      done_d = 1'b0;

      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            base_d   = i_base;
            len_d    = i_len;
            stride_d = i_stride;
            dwell_d  = i_dwell;
            pause_d  = i_pause;
            wrap_d   = i_wrap;
`ifdef ADDR_GEN_SEQ_REPEAT_EN
            rep_d    = i_repeat;
`endif
            if (i_len == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = DWELL;
              addr_d  = i_base;
              valid_d = 1'b1;
              last_d  = (i_len == A_ONE);
              busy_d  = 1'b1;
              idx_d   = '0;
              cnt_d   = dwell_m1(i_dwell);
            end
          end
        end

        DWELL: begin
          if (i_stop) begin
            halt = 1'b1;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - C_ONE;
          end else if (pause_q != '0) begin
            state_d = PAUSE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            cnt_d   = pause_q - C_ONE;
          end else begin
            step = 1'b1;
          end
        end

        PAUSE: begin
          if (i_stop) begin
            halt = 1'b1;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - C_ONE;
          end else begin
            step = 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase

      if (step) begin
        if (idx_q != len_m1) begin
          state_d = DWELL;
          addr_d  = addr_q + stride_q;
          idx_d   = idx_inc;
          valid_d = 1'b1;
          last_d  = (idx_inc == len_m1);
          cnt_d   = dwell_m1(dwell_q);
        end else if (wrap_q) begin
          state_d = DWELL;
          addr_d  = base_q;
          idx_d   = '0;
          valid_d = 1'b1;
          last_d  = (len_q == A_ONE);
          cnt_d   = dwell_m1(dwell_q);
`ifdef ADDR_GEN_SEQ_REPEAT_EN
        end else if (rep_q != 8'd0) begin
          state_d = DWELL;
          addr_d  = base_q;
          idx_d   = '0;
          valid_d = 1'b1;
          last_d  = (len_q == A_ONE);
          cnt_d   = dwell_m1(dwell_q);
          rep_d   = rep_q - 8'd1;
`endif
        end else begin
          halt = 1'b1;
        end
      end

      if (halt) begin
        state_d = IDLE;
        addr_d  = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        idx_d   = '0;
        cnt_d   = '0;
      end
    end
  end

  assign o_addr  = addr_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_addr_gen_seq.sv
// tb_addr_gen_seq: directed stimulus, scoreboard of timed output events.
// Define ADDR_GEN_SEQ_REPEAT_EN to also exercise multi-pass repeat.
module tb_addr_gen_seq;

  localparam int AW = 12;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          i_start;
  logic          i_stop;
  logic [AW-1:0] i_base;
  logic [AW-1:0] i_len;
  logic [AW-1:0] i_stride;
  logic [CW-1:0] i_dwell;
  logic [CW-1:0] i_pause;
  logic          i_wrap;
`ifdef ADDR_GEN_SEQ_REPEAT_EN
  logic [7:0]    i_repeat;
`endif
  logic [AW-1:0] o_addr;
  logic          o_valid;
  logic          o_last;
  logic          o_busy;
  logic          o_done;

  addr_gen_seq #(
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .i_start (i_start),
    .i_stop  (i_stop),
    .i_base  (i_base),
    .i_len   (i_len),
    .i_stride(i_stride),
    .i_dwell (i_dwell),
    .i_pause (i_pause),
    .i_wrap  (i_wrap),
`ifdef ADDR_GEN_SEQ_REPEAT_EN
    .i_repeat(i_repeat),
`endif
    .o_addr  (o_addr),
    .o_valid (o_valid),
    .o_last  (o_last),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic          last;
    logic          done;
  } ev_t;

  ev_t sb[$];
  int  cyc   = 0;
  int  t0    = 0;
  int  nrun  = 0;
  int  nfail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every valid or done cycle must match the next expected event
  always @(negedge clk) begin
    ev_t e;
    if (!rst && (o_valid || o_done)) begin
      nrun++;
      if (sb.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_out cyc=%0d addr=%0d v=%b l=%b d=%b, no event expected",
                 cyc, o_addr, o_valid, o_last, o_done);
      end else begin
        e = sb.pop_front();
        if (cyc != e.cyc || o_addr != e.addr || o_last != e.last ||
            o_done != e.done || o_valid != !e.done || o_busy != !e.done) begin
          nfail++;
          $display("FAIL event got cyc=%0d addr=%0d v=%b l=%b b=%b d=%b, want cyc=%0d addr=%0d v=%b l=%b b=%b d=%b",
                   cyc, o_addr, o_valid, o_last, o_busy, o_done,
                   e.cyc, e.addr, !e.done, e.last, !e.done, e.done);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    nrun++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      i_start = 1'b0;
      i_stop  = 1'b0;
    end
  endtask

  // drive a start; the following edge samples it
  task automatic go(input int b, input int l, input int s,
                    input int d, input int p, input bit w);
    i_base   = AW'(b);
    i_len    = AW'(l);
    i_stride = AW'(s);
    i_dwell  = CW'(d);
    i_pause  = CW'(p);
    i_wrap   = w;
    i_start  = 1'b1;
    t0       = cyc + 1;
  endtask

  task automatic ev(input int off, input int a, input bit l, input bit d);
    ev_t e;
    e.cyc  = t0 + off;
    e.addr = AW'(a);
    e.last = l;
    e.done = d;
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; i_start = 1'b0; i_stop = 1'b0;
    i_base = '0; i_len = '0; i_stride = '0;
    i_dwell = '0; i_pause = '0; i_wrap = 1'b0;
`ifdef ADDR_GEN_SEQ_REPEAT_EN
    i_repeat = '0;
`endif
    tick(2);
    chk("rst_outs", {o_addr, o_valid, o_last, o_busy, o_done}, 0);
    rst = 1'b0;
    tick(1);

    // basic walk, with an ignored start mid-run
    go(10, 4, 3, 2, 1, 1'b0);
    ev(0, 10, 0, 0); ev(1, 10, 0, 0);
    ev(3, 13, 0, 0); ev(4, 13, 0, 0);
    ev(6, 16, 0, 0); ev(7, 16, 0, 0);
    ev(9, 19, 1, 0); ev(10, 19, 1, 0);
    ev(12, 0, 0, 1);
    tick(1);
    tick(2);
    chk("pause_valid", o_valid, 0);
    chk("pause_addr", o_addr, 10);
    chk("pause_busy", o_busy, 1);
    tick(1);
    i_start = 1'b1; i_base = 12'd999; i_len = 12'd1;
    tick(11);

    // wrap, then stop while o_addr=1
    go(0, 3, 1, 1, 0, 1'b1);
    ev(0, 0, 0, 0); ev(1, 1, 0, 0); ev(2, 2, 1, 0);
    ev(3, 0, 0, 0); ev(4, 1, 0, 0);
    ev(5, 0, 0, 1);
    tick(1);
    tick(4);
    i_stop = 1'b1;
    tick(1);
    chk("stop_busy", o_busy, 0);
    tick(2);

    // stop in idle does nothing
    i_stop = 1'b1;
    tick(3);

    // len=0: done only
    go(33, 0, 1, 1, 0, 1'b0);
    ev(0, 0, 0, 1);
    tick(4);

    // dwell=0 acts as dwell=1
    go(5, 2, 2, 0, 0, 1'b0);
    ev(0, 5, 0, 0); ev(1, 7, 1, 0); ev(2, 0, 0, 1);
    tick(5);

    // address wraps modulo 2^12
    go(4094, 3, 3, 1, 0, 1'b0);
    ev(0, 4094, 0, 0); ev(1, 1, 0, 0); ev(2, 4, 1, 0);
    ev(3, 0, 0, 1);
    tick(6);

    // freeze for 5 cycles mid-dwell
    go(100, 2, 10, 3, 0, 1'b0);
    for (int k = 0; k < 8; k++) ev(k, 100, 0, 0);
    ev(8, 110, 1, 0); ev(9, 110, 1, 0); ev(10, 110, 1, 0);
    ev(11, 0, 0, 1);
    tick(1);
    en = 1'b0;
    tick(5);
    en = 1'b1;
    tick(8);

    // async reset mid-pause, no done pulse
    go(20, 2, 1, 1, 2, 1'b0);
    ev(0, 20, 0, 0);
    tick(2);
    chk("p2_valid", o_valid, 0);
    chk("p2_addr", o_addr, 20);
    rst = 1'b1;
    #1;
    chk("arst_outs", {o_addr, o_valid, o_last, o_busy, o_done}, 0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // back-to-back start in the done cycle
    go(7, 1, 0, 1, 0, 1'b0);
    ev(0, 7, 1, 0); ev(1, 0, 0, 1);
    tick(2);
    chk("b2b_done", o_done, 1);
    go(50, 1, 0, 1, 0, 1'b0);
    ev(0, 50, 1, 0); ev(1, 0, 0, 1);
    tick(4);

`ifdef ADDR_GEN_SEQ_REPEAT_EN
    // three passes of two addresses, one done
    i_repeat = 8'd2;
    go(30, 2, 5, 1, 0, 1'b0);
    ev(0, 30, 0, 0); ev(1, 35, 1, 0);
    ev(2, 30, 0, 0); ev(3, 35, 1, 0);
    ev(4, 30, 0, 0); ev(5, 35, 1, 0);
    ev(6, 0, 0, 1);
    tick(9);
    i_repeat = 8'd0;
`endif

    tick(3);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule

// File: doc/addr_gen_seq.md
# addr_gen_seq

Parametrised, runtime-configurable memory address sequencer for the LSTM datapath. It walks a weight or activation buffer from a base address with a programmable stride and length. Each address is held for a programmable dwell time, followed by an optional pause. It supports one-shot or wrap-around operation, with a start/busy/done handshake. It sits between the layer controller and the weight/state RAM address ports, and supersedes the fixed-constant generators.

## Interface
Parameters:
- ADDR_WIDTH, 12, width of address, length and stride
- CNT_WIDTH, 12, width of dwell and pause counters

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  clock enable; 0 freezes all state and outputs
- i_start  in  1  start request, sampled in IDLE only
- i_stop  in  1  abort request, sampled while busy
- i_base  in  ADDR_WIDTH  first address of a pass
- i_len  in  ADDR_WIDTH  addresses per pass
- i_stride  in  ADDR_WIDTH  address increment
- i_dwell  in  CNT_WIDTH  cycles each address is valid; 0 treated as 1
- i_pause  in  CNT_WIDTH  idle cycles after each address; 0 = none
- i_wrap  in  1  1 = restart at base after last address, runs until i_stop
- o_addr  out  ADDR_WIDTH  current address
- o_valid  out  1  o_addr is to be used this cycle
- o_last  out  1  high with o_valid on the last address of a pass
- o_busy  out  1  sequence in progress
- o_done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, DWELL, PAUSE. All outputs are registered.
- Reset values: state IDLE. o_addr=0, o_valid=0, o_last=0, o_busy=0, o_done=0. All internal counters are 0.
- Every transition below requires en=1. With en=0, state, counters and outputs hold their values. o_done is held, not re-pulsed.
- On i_start=1 in IDLE, i_base, i_len, i_stride, i_dwell, i_pause and i_wrap are latched. Later input changes are ignored until the next start.
- IDLE -> DWELL on i_start with i_len≠0: o_addr=i_base, o_valid=1, o_busy=1, and the index is set to 0.
- IDLE with i_start and i_len=0: stays in IDLE and pulses o_done for 1 cycle. o_valid stays 0.
- DWELL: o_valid=1 for max(dwell,1) cycles. On the final dwell cycle the next edge moves as follows:
  - to PAUSE if pause≠0, with o_valid=0 and o_addr held;
  - otherwise directly to the next address.
- PAUSE: lasts exactly pause cycles, then moves to the next address.
- Next address, when index < len-1: o_addr += stride, modulo 2^ADDR_WIDTH (wraps silently), index += 1, state DWELL.
- End of pass, when index = len-1:
  - wrap=1: o_addr=base, index=0, state DWELL.
  - wrap=0: state IDLE, o_addr=0, o_busy=0, o_done=1 for one cycle.
- o_last = o_valid and (index = len-1).
- i_stop=1 while busy: the next edge forces IDLE, o_addr=0, o_valid=0, o_busy=0, o_done=1. i_stop has priority over all other transitions.
- i_start while busy is ignored. i_stop in IDLE is ignored.

## Timing
- Start latency: 1 cycle. i_start is sampled at edge k, and o_valid/o_addr=base are visible after edge k.
- Cycles per address = max(dwell,1) + pause.
- One-shot pass: o_done is asserted len·(max(dwell,1)+pause) cycles after the start edge, in the cycle after the final dwell/pause cycle.
- Back-to-back: i_start can be accepted in the cycle o_done is high, because state is already IDLE.
- rst is asynchronous. Mid-operation, all outputs return to reset values immediately, with no o_done pulse.

## Configuration
- ADDR_GEN_SEQ_REPEAT_EN defined:
  - Adds port i_repeat (in, 8 bits), latched on start.
  - With wrap=0, the block runs i_repeat+1 passes, each restarting at base, and pulses o_done only after the final pass.
  - o_last marks the last address of every pass.
  - wrap=1 ignores i_repeat.
- Not defined: the port is absent and exactly one pass is run when wrap=0.

## Test plan
- Basic walk: base=10, len=4, stride=3, dwell=2, pause=1, wrap=0.
  - o_addr sequence is 10,13,16,19; each valid 2 cycles, then 1 idle cycle.
  - o_last is high on 19; o_done pulses at cycle 12 after start; o_addr then returns to 0.
- Wrap and stop: base=0, len=3, stride=1, dwell=1, pause=0, wrap=1.
  - o_addr runs 0,1,2,0,1 continuously.
  - i_stop asserted while o_addr=1 gives IDLE, o_addr=0 and o_done=1 on the next edge.
- Edge values:
  - len=0 gives a single o_done and no o_valid.
  - dwell=0 behaves as dwell=1.
  - ADDR_WIDTH=12 with base=4094, stride=3 gives addresses 4094, 1, 4.
- Freeze: en deasserted for 5 cycles mid-DWELL. Outputs and remaining dwell are unchanged; the sequence resumes exactly after en returns.
- Reset and restart:
  - rst asserted mid-PAUSE clears all outputs asynchronously with no o_done.
  - i_start in the o_done cycle starts a new pass on the next edge.
- With ADDR_GEN_SEQ_REPEAT_EN, i_repeat=2, len=2: o_addr runs base,base+s three times, with o_last three times and a single o_done.
